// File: rtl/mux_16x1_scanner.sv
// Purpose: walks mux_16x1 select over the enabled channels of a latched mask and assembles the samples into one word.
// Latency: N enabled channels -> word_valid after N+1 edges from start (1 edge for an empty mask); one channel per cycle.
// Backpressure: word held with word_valid until word_ack; start is ignored (not queued) while scanning or holding.
//
// Ports:
//   clk, rst       single clock, synchronous active-high reset
//   start, mask    scan request and channel-enable mask (mask latched at accepted start)
//   mux_out        mux_16x1.data_out, sampled one edge after select is registered
//   select         registered channel select driven to mux_16x1
//   busy           high while scanning
//   word_out       assembled word, bit i = channel i sample, disabled bits 0
//   word_valid     word_out ready and stable
//   word_ack       consumer acknowledge, only honoured while word_valid
module mux_16x1_scanner (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] mask,
    input  logic        mux_out,
    output logic [3:0]  select,
    output logic        busy,
    output logic [15:0] word_out,
    output logic        word_valid,
    input  logic        word_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  select_nxt;
    logic [15:0] word_nxt;
    logic [15:0] mask_q, mask_nxt;

    logic [3:0]  first_idx;     // lowest set bit of the incoming mask
    logic [3:0]  next_idx;      // next set bit of the latched mask above select
    logic        next_found;

    // Scanning downward leaves the lowest matching index as the final assignment.
    always_comb begin
        first_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                first_idx = 4'(i);
            end
        end
    end

    always_comb begin
        next_idx   = 4'd0;
        next_found = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (mask_q[i] && (4'(i) > select)) begin
                next_idx   = 4'(i);
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        select_nxt = select;
        word_nxt   = word_out;
        mask_nxt   = mask_q;
        case (state)
            IDLE: begin
                select_nxt = 4'd0;
                if (start) begin
                    mask_nxt = mask;
                    word_nxt = 16'h0000;
                    if (mask != 16'h0000) begin
                        state_nxt  = SCAN;
                        select_nxt = first_idx;
                    end else begin
                        state_nxt = HOLD;
                    end
                end
            end
            SCAN: begin
                // mux_out reflects the select registered on the previous edge.
                word_nxt[select] = mux_out;
                if (next_found) begin
                    select_nxt = next_idx;
                end else begin
                    state_nxt  = HOLD;
                    select_nxt = 4'd0;
                end
            end
            HOLD: begin
                if (word_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt  = IDLE;
                select_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            select   <= 4'd0;
            word_out <= 16'h0000;
            mask_q   <= 16'h0000;
        end else begin
            state    <= state_nxt;
            select   <= select_nxt;
            word_out <= word_nxt;
            mask_q   <= mask_nxt;
        end
    end

    assign busy       = (state == SCAN);
    assign word_valid = (state == HOLD);

endmodule

// File: tb/tb_mux_16x1_scanner.sv
module tb_mux_16x1_scanner;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] mask;
    logic        mux_out;
    logic [3:0]  select;
    logic        busy;
    logic [15:0] word_out;
    logic        word_valid;
    logic        word_ack;
    logic [15:0] data_in;

    int n_checks;
    int n_fail;

    // Behavioural stand-in for mux_16x1: purely combinational channel pick.
    assign mux_out = data_in[select];

    mux_16x1_scanner dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mask       (mask),
        .mux_out    (mux_out),
        .select     (select),
        .busy       (busy),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ack   (word_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: the word is data gated by mask; channels are the set mask
    // bits in ascending order, one per cycle.
    task automatic run_scan(input logic [15:0] d, input logic [15:0] m, input bit scramble);
        int          ch[$];
        logic [15:0] expw;
        expw = d & m;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) ch.push_back(i);
        end
        data_in = d;
        mask    = m;
        start   = 1'b1;
        step();
        start = 1'b0;
        if (scramble) mask = 16'($urandom);
        for (int k = 0; k < ch.size(); k++) begin
            check("scan_busy", {15'd0, busy}, 16'd1);
            check("scan_select", {12'd0, select}, 16'(ch[k]));
            check("scan_valid", {15'd0, word_valid}, 16'd0);
            step();
        end
        check("hold_valid", {15'd0, word_valid}, 16'd1);
        check("hold_busy", {15'd0, busy}, 16'd0);
        check("hold_word", word_out, expw);
        check("hold_select", {12'd0, select}, 16'd0);
        word_ack = 1'b1;
        step();
        word_ack = 1'b0;
        check("ack_valid", {15'd0, word_valid}, 16'd0);
        check("ack_word_kept", word_out, expw);
    endtask

    initial begin
        logic [15:0] m;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        mask     = 16'h0000;
        word_ack = 1'b0;
        data_in  = 16'h0000;
        step();
        step();
        check("rst_select", {12'd0, select}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_word", word_out, 16'h0000);
        check("rst_valid", {15'd0, word_valid}, 16'd0);
        rst = 1'b0;
        step();
        check("idle_select", {12'd0, select}, 16'd0);

        // Reset in the middle of a full scan discards the partial word.
        data_in = 16'h09EE;
        mask    = 16'hFFFF;
        start   = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        check("midscan_busy", {15'd0, busy}, 16'd1);
        rst = 1'b1;
        step();
        step();
        check("midrst_select", {12'd0, select}, 16'd0);
        check("midrst_busy", {15'd0, busy}, 16'd0);
        check("midrst_word", word_out, 16'h0000);
        check("midrst_valid", {15'd0, word_valid}, 16'd0);
        rst = 1'b0;
        repeat (3) step();
        check("postrst_valid", {15'd0, word_valid}, 16'd0);
        check("postrst_busy", {15'd0, busy}, 16'd0);

        // Reset and start on the same edge: reset wins.
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy", {15'd0, busy}, 16'd0);
        check("rst_start_valid", {15'd0, word_valid}, 16'd0);

        // Directed cases.
        run_scan(16'b0000100111101110, 16'hFFFF, 1'b0);
        run_scan(16'h0040, 16'h00F0, 1'b0);
        run_scan(16'hC000, 16'h8001, 1'b0);
        run_scan(16'hFFFF, 16'h0000, 1'b0);
        run_scan(16'h5A5A, 16'h00F0, 1'b1);

        // Handshake: start ignored during SCAN and HOLD, word held without ack.
        data_in = 16'h0040;
        mask    = 16'h00F0;
        start   = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("hs_scan_sel", {12'd0, select}, 16'd6);
        step();
        step();
        for (int c = 0; c < 5; c++) begin
            start = c[0];
            check("hs_hold_valid", {15'd0, word_valid}, 16'd1);
            check("hs_hold_word", word_out, 16'h0040);
            step();
        end
        start    = 1'b0;
        check("hs_still_valid", {15'd0, word_valid}, 16'd1);
        check("hs_no_busy", {15'd0, busy}, 16'd0);
        word_ack = 1'b1;
        step();
        word_ack = 1'b0;
        check("hs_ack_valid", {15'd0, word_valid}, 16'd0);
        mask  = 16'h0C00;
        start = 1'b1;
        step();
        start = 1'b0;
        check("hs_restart_busy", {15'd0, busy}, 16'd1);
        check("hs_restart_sel", {12'd0, select}, 16'd10);
        check("hs_restart_word", word_out, 16'h0000);
        step();
        step();
        check("hs_restart_valid", {15'd0, word_valid}, 16'd1);
        check("hs_restart_result", word_out, 16'h0000);
        word_ack = 1'b1;
        step();
        word_ack = 1'b0;

        // Word_ack outside HOLD is ignored.
        word_ack = 1'b1;
        step();
        word_ack = 1'b0;
        check("idle_ack_valid", {15'd0, word_valid}, 16'd0);

        // Randomized scans, with some sparse and some empty masks.
        for (int r = 0; r < 24; r++) begin
            m = 16'($urandom);
            if (r % 4 == 1) m = m & 16'($urandom) & 16'($urandom);
            if (r % 8 == 3) m = 16'h0000;
            run_scan(16'($urandom), m, r[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
